// File: rtl/demux_deser_1x8.sv
// rtl/demux_deser_1x8.sv - 1:8 serial-to-parallel demultiplexing deserializer
//
// Purpose:
//   Takes one serial bit per accepted beat and steers it, through a 1:WIDTH
//   demultiplexer selected by an internal slot counter, into the matching bit
//   of an assembly register. When the last slot is written, the completed word
//   moves to a held output register that drains through a valid/ready
//   handshake.
//
// Ports:
//   clk       - clock; all state updates on the rising edge
//   rst       - asynchronous active-high reset
//   clr       - synchronous discard of the partial word (held word kept)
//   in_bit    - serial data bit
//   in_valid  - in_bit is valid this cycle
//   in_ready  - block accepts in_bit this cycle
//   slot      - destination bit position of the next accepted bit
//   out_byte  - assembled word, stable while out_valid is high
//   out_valid - out_byte holds an unconsumed word
//   out_ready - consumer takes out_byte this cycle

module demux_deser_1x8 #(
    parameter int WIDTH     = 8,
    parameter int SEL_W     = 3,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_bit,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [SEL_W-1:0] slot,
    output logic [WIDTH-1:0] out_byte,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam logic [SEL_W-1:0] SLOT_LOW   = '0;
    localparam logic [SEL_W-1:0] SLOT_HIGH  = SEL_W'(WIDTH - 1);
    localparam logic [SEL_W-1:0] SLOT_ONE   = SEL_W'(1);

    // Fill order decides where a word starts and which slot completes it.
    localparam logic [SEL_W-1:0] SLOT_START = LSB_FIRST ? SLOT_LOW  : SLOT_HIGH;
    localparam logic [SEL_W-1:0] SLOT_LAST  = LSB_FIRST ? SLOT_HIGH : SLOT_LOW;

    logic [SEL_W-1:0] slot_q,      slot_d;
    logic [WIDTH-1:0] asm_q,       asm_d;
    logic [WIDTH-1:0] out_byte_q,  out_byte_d;
    logic             out_valid_q, out_valid_d;

    logic             at_last;
    logic             accept;
    logic             consume;
    logic [WIDTH-1:0] merged;

    assign at_last = (slot_q == SLOT_LAST);

    // Non-last bits are always taken; the final bit needs somewhere to go,
    // i.e. an empty output register or one being drained this very cycle.
    assign in_ready = ~at_last | ~out_valid_q | out_ready;
    assign accept   = in_valid & in_ready;
    assign consume  = out_valid_q & out_ready;

    // Assembly register with the incoming bit steered into the current slot.
    always_comb begin
        merged         = asm_q;
        merged[slot_q] = in_bit;
    end

    always_comb begin
        slot_d      = slot_q;
        asm_d       = asm_q;
        out_byte_d  = out_byte_q;
        // A drained word clears valid unless a completion reloads it below.
        out_valid_d = out_valid_q & ~consume;

        if (clr) begin
            // Partial word is discarded; any accept on this edge is dropped.
            slot_d = SLOT_START;
            asm_d  = '0;
        end else if (accept) begin
            if (at_last) begin
                out_byte_d  = merged;
                out_valid_d = 1'b1;
                slot_d      = SLOT_START;
                asm_d       = '0;
            end else begin
                asm_d  = merged;
                slot_d = LSB_FIRST ? (slot_q + SLOT_ONE) : (slot_q - SLOT_ONE);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q      <= SLOT_START;
            asm_q       <= '0;
            out_byte_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            slot_q      <= slot_d;
            asm_q       <= asm_d;
            out_byte_q  <= out_byte_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign slot      = slot_q;
    assign out_byte  = out_byte_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_demux_deser_1x8.sv
// tb/tb_demux_deser_1x8.sv - directed self-checking bench for demux_deser_1x8

module tb_demux_deser_1x8;

    logic       clk;
    logic       rst;

    logic       clr;
    logic       in_bit;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] slot;
    logic [7:0] out_byte;
    logic       out_valid;
    logic       out_ready;

    logic       b_clr;
    logic       b_in_bit;
    logic       b_in_valid;
    logic       b_in_ready;
    logic [2:0] b_slot;
    logic [7:0] b_out_byte;
    logic       b_out_valid;
    logic       b_out_ready;

    int n_checks;
    int n_fail;

    logic [7:0] word;

    demux_deser_1x8 #(.WIDTH(8), .SEL_W(3), .LSB_FIRST(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_bit    (in_bit),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .slot      (slot),
        .out_byte  (out_byte),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    demux_deser_1x8 #(.WIDTH(8), .SEL_W(3), .LSB_FIRST(1'b0)) dut_msb (
        .clk       (clk),
        .rst       (rst),
        .clr       (b_clr),
        .in_bit    (b_in_bit),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .slot      (b_slot),
        .out_byte  (b_out_byte),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        in_valid = 1'b1;
        in_bit   = b;
        tick();
    endtask

    task automatic send_bit_b(input logic b);
        b_in_valid = 1'b1;
        b_in_bit   = b;
        tick();
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst         = 1'b1;
        clr         = 1'b0;
        in_bit      = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        b_clr       = 1'b0;
        b_in_bit    = 1'b0;
        b_in_valid  = 1'b0;
        b_out_ready = 1'b1;

        // Reset state, observed before any clock edge.
        #2;
        chk("rst_slot",      slot,      0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_byte",  out_byte,  0);
        chk("rst_in_ready",  in_ready,  1);
        chk("rst_msb_slot",  b_slot,    7);
        tick();
        rst = 1'b0;
        tick();

        // Basic LSB-first word: 0,1,0,1,... -> 8'b10101010
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send_bit(logic'(i % 2));
            if (i < 7) begin
                chk("basic_slot",  slot,      i + 1);
                chk("basic_valid", out_valid, 0);
            end
        end
        chk("basic_byte",  out_byte,  8'hAA);
        chk("basic_valid", out_valid, 1);
        chk("basic_wrap",  slot,      0);
        in_valid = 1'b0;
        tick();
        chk("basic_consumed", out_valid, 0);
        chk("basic_keep",     out_byte,  8'hAA);

        // Back-to-back A5 then 3C, one bit per cycle, no bubble.
        for (int i = 0; i < 16; i++) begin
            word     = (i < 8) ? 8'hA5 : 8'h3C;
            in_valid = 1'b1;
            in_bit   = word[i % 8];
            chk("b2b_in_ready", in_ready, 1);
            tick();
            if (i == 7) begin
                chk("b2b_valid_a5", out_valid, 1);
                chk("b2b_byte_a5",  out_byte,  8'hA5);
            end else if (i == 15) begin
                chk("b2b_valid_3c", out_valid, 1);
                chk("b2b_byte_3c",  out_byte,  8'h3C);
            end else begin
                chk("b2b_valid_low", out_valid, 0);
            end
        end
        in_valid = 1'b0;
        tick();

        // Back-pressure: FF held, then 7 zeros, final bit stalls.
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send_bit(1'b1);
        chk("bp_valid_ff", out_valid, 1);
        chk("bp_byte_ff",  out_byte,  8'hFF);
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_bit   = 1'b0;
            chk("bp_nonlast_ready", in_ready, 1);
            tick();
        end
        chk("bp_slot7", slot, 7);
        in_valid = 1'b1;
        in_bit   = 1'b0;
        chk("bp_stall_ready", in_ready, 0);
        tick();
        tick();
        chk("bp_stall_slot",  slot,      7);
        chk("bp_stall_byte",  out_byte,  8'hFF);
        chk("bp_stall_valid", out_valid, 1);
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 1);
        tick();
        chk("bp_reload_valid", out_valid, 1);
        chk("bp_reload_byte",  out_byte,  8'h00);
        chk("bp_reload_slot",  slot,      0);
        in_valid = 1'b0;
        tick();
        chk("bp_drained", out_valid, 0);

        // clr mid-word: the bit on the clr edge is dropped.
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        chk("clr_pre_slot", slot, 4);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_bit   = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_slot", slot, 0);
        out_ready = 1'b0;
        word = 8'h0F;
        for (int i = 0; i < 8; i++) send_bit(word[i]);
        chk("clr_word_byte",  out_byte,  8'h0F);
        chk("clr_word_valid", out_valid, 1);
        // clr while a word is held leaves it alone.
        send_bit(1'b1);
        clr      = 1'b1;
        in_valid = 1'b0;
        tick();
        clr = 1'b0;
        chk("clr_held_valid", out_valid, 1);
        chk("clr_held_byte",  out_byte,  8'h0F);
        chk("clr_held_slot",  slot,      0);

        // Async reset with a held word and slot=5, observed between edges.
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        in_valid = 1'b0;
        chk("arst_pre_slot",  slot,      5);
        chk("arst_pre_valid", out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_byte",  out_byte,  0);
        chk("arst_slot",  slot,      0);
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        tick();

        // MSB-first instance: slots step 7 down to 0.
        chk("msb_start_slot", b_slot, 7);
        for (int i = 0; i < 8; i++) begin
            send_bit_b(logic'((i + 1) % 2));
            if (i < 7) chk("msb_slot", b_slot, 6 - i);
        end
        chk("msb_byte",  b_out_byte,  8'hAA);
        chk("msb_valid", b_out_valid, 1);
        chk("msb_wrap",  b_slot,      7);
        b_in_valid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
